// File: rtl/uart_tx_buffered_pkg.sv
// Shared constants and FSM state type for the buffered UART transmitter.
// The default bit timing matches the uart_rx block on the far end of the link.
package uart_tx_buffered_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 1085;
  localparam int DEFAULT_WORD         = 9;
  localparam int DEFAULT_FIFO_DEPTH   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Producer-side valid/ready handshake into the transmitter FIFO.
// The master modport is the word producer; the slave modport is the transmitter.
interface uart_tx_buffered_if
  import uart_tx_buffered_pkg::*;
#(
  parameter int WORD       = DEFAULT_WORD,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic             i_Tx_DV;
  logic [WORD-1:0]  i_Tx_Byte;
  logic             o_Tx_Ready;
  logic [CNT_W-1:0] o_Fifo_Count;

  modport master (
    output i_Tx_DV,
    output i_Tx_Byte,
    input  o_Tx_Ready,
    input  o_Fifo_Count
  );

  modport slave (
    input  i_Tx_DV,
    input  i_Tx_Byte,
    output o_Tx_Ready,
    output o_Fifo_Count
  );

endinterface

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Small synchronous FIFO with a first-word-fall-through read port.
// Push is ignored while full and pop is ignored while empty.
module uart_tx_buffered_sync_fifo
  import uart_tx_buffered_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WORD,
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                       i_Clock,
  input  logic                       i_Rst_n,
  input  logic                       i_Push,
  input  logic [WIDTH-1:0]           i_Data,
  input  logic                       i_Pop,
  output logic [WIDTH-1:0]           o_Data,
  output logic                       o_Full,
  output logic                       o_Empty,
  output logic [$clog2(DEPTH+1)-1:0] o_Count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  assign o_Full  = (count_q == CNT_W'(DEPTH));
  assign o_Empty = (count_q == '0);
  assign o_Count = count_q;
  assign o_Data  = mem_q[rd_ptr_q];
  assign push_ok = i_Push && !o_Full;
  assign pop_ok  = i_Pop && !o_Empty;

  always_ff @(posedge i_Clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= i_Data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: queued words are sent as start/data/stop frames,
// LSB first, back-to-back with no idle gap while the FIFO holds data.
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int WORD         = DEFAULT_WORD,
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
  parameter int STOP_BITS    = 1
) (
  input  logic              i_Clock,
  input  logic              i_Rst_n,
  uart_tx_buffered_if.slave tx_if,
  output logic              o_Tx_Serial,
  output logic              o_Tx_Active,
  output logic              o_Tx_Done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(WORD);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  tx_state_e         state_q;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]  bit_idx_q;
  logic              stop_idx_q;
  logic [WORD-1:0]   shift_q;
  logic              serial_q, active_q, done_q;

  logic              fifo_full, fifo_empty, fifo_pop;
  logic [WORD-1:0]   fifo_data;
  logic [CNT_W-1:0]  fifo_count;
  logic              baud_end, last_stop;

  uart_tx_buffered_sync_fifo #(
    .WIDTH (WORD),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Clock (i_Clock),
    .i_Rst_n (i_Rst_n),
    .i_Push  (tx_if.i_Tx_DV),
    .i_Data  (tx_if.i_Tx_Byte),
    .i_Pop   (fifo_pop),
    .o_Data  (fifo_data),
    .o_Full  (fifo_full),
    .o_Empty (fifo_empty),
    .o_Count (fifo_count)
  );

  // Ready looks only at full, so a push on a popping-while-full edge is refused.
  assign tx_if.o_Tx_Ready   = !fifo_full;
  assign tx_if.o_Fifo_Count = fifo_count;

  assign baud_end  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign baud_d    = baud_end ? '0 : baud_q + BAUD_W'(1);
  assign last_stop = (stop_idx_q == 1'(STOP_BITS - 1));
  assign fifo_pop  = !fifo_empty &&
                     ((state_q == ST_IDLE) ||
                      (state_q == ST_STOP && baud_end && last_stop));

  assign o_Tx_Serial = serial_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Done   = done_q;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      serial_q   <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          baud_q <= '0;
          if (!fifo_empty) begin
            shift_q  <= fifo_data;
            serial_q <= 1'b0;
            active_q <= 1'b1;
            state_q  <= ST_START;
          end
        end

        ST_START: begin
          baud_q <= baud_d;
          if (baud_end) begin
            serial_q  <= shift_q[0];
            shift_q   <= {1'b0, shift_q[WORD-1:1]};
            bit_idx_q <= '0;
            state_q   <= ST_DATA;
          end
        end

        ST_DATA: begin
          baud_q <= baud_d;
          if (baud_end) begin
            if (bit_idx_q == BIT_W'(WORD - 1)) begin
              serial_q   <= 1'b1;
              stop_idx_q <= 1'b0;
              state_q    <= ST_STOP;
            end else begin
              serial_q  <= shift_q[0];
              shift_q   <= {1'b0, shift_q[WORD-1:1]};
              bit_idx_q <= bit_idx_q + BIT_W'(1);
            end
          end
        end

        ST_STOP: begin
          baud_q <= baud_d;
          if (baud_end) begin
            if (last_stop) begin
              // Chain straight into the next start bit when a word is waiting.
              done_q <= 1'b1;
              if (!fifo_empty) begin
                shift_q  <= fifo_data;
                serial_q <= 1'b0;
                state_q  <= ST_START;
              end else begin
                active_q <= 1'b0;
                state_q  <= ST_IDLE;
              end
            end else begin
              stop_idx_q <= stop_idx_q + 1'b1;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: reset, single frame, back-to-back burst,
// full-FIFO refusal, mid-frame reset and a loopback-style word decode.
module tb_uart_tx_buffered;

  localparam int CPB   = 16;
  localparam int WORD  = 9;
  localparam int DEPTH = 4;
  localparam int HALF  = CPB / 2;

  logic clock  = 1'b0;
  logic resetN = 1'b0;
  logic txSerial, txActive, txDone;

  int vecCount  = 0;
  int missCount = 0;
  int doneCount = 0;
  int doneMark;

  logic [10:0]     cap;
  logic [WORD-1:0] burst [6];
  int              countAfter [5];
  logic            sawLow, sawDone;

  uart_tx_buffered_if #(.WORD(WORD), .FIFO_DEPTH(DEPTH)) txIf ();

  uart_tx_buffered #(
    .CLKS_PER_BIT (CPB),
    .WORD         (WORD),
    .FIFO_DEPTH   (DEPTH),
    .STOP_BITS    (1)
  ) dut (
    .i_Clock     (clock),
    .i_Rst_n     (resetN),
    .tx_if       (txIf),
    .o_Tx_Serial (txSerial),
    .o_Tx_Active (txActive),
    .o_Tx_Done   (txDone)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (txDone === 1'b1) doneCount <= doneCount + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    assert (observed === expected)
    else begin
      missCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic dv, input logic [WORD-1:0] word);
    txIf.i_Tx_DV   = dv;
    txIf.i_Tx_Byte = word;
  endtask

  // Samples the line mid-bit; offset is how many cycles past the line fall we are.
  task automatic captureFrame(input int offset, output logic [10:0] frame);
    tick(HALF - offset);
    frame[0] = txSerial;
    for (int i = 1; i < 11; i++) begin
      tick(CPB);
      frame[i] = txSerial;
    end
  endtask

  function automatic logic [10:0] makeFrame(input logic [WORD-1:0] w);
    return {1'b1, w, 1'b0};
  endfunction

  initial begin
    burst      = '{9'h03F, 9'h100, 9'h1FF, 9'h000, 9'h155, 9'h0AA};
    countAfter = '{3, 2, 1, 0, 0};
    applyStimulus(1'b0, '0);

    // Reset values
    tick(3);
    checkOutput("rst_serial", 32'(txSerial), 32'd1);
    checkOutput("rst_ready",  32'(txIf.o_Tx_Ready), 32'd1);
    checkOutput("rst_count",  32'(txIf.o_Fifo_Count), 32'd0);
    checkOutput("rst_active", 32'(txActive), 32'd0);
    checkOutput("rst_done",   32'(doneCount), 32'd0);
    resetN = 1'b1;
    tick(3);

    // Single word 0x0AB: line falls one cycle after the push edge
    doneMark = doneCount;
    applyStimulus(1'b1, 9'h0AB);
    tick(1);
    applyStimulus(1'b0, '0);
    checkOutput("t2_push_serial", 32'(txSerial), 32'd1);
    checkOutput("t2_push_count",  32'(txIf.o_Fifo_Count), 32'd1);
    tick(1);
    checkOutput("t2_fall",        32'(txSerial), 32'd0);
    checkOutput("t2_active",      32'(txActive), 32'd1);
    checkOutput("t2_pop_count",   32'(txIf.o_Fifo_Count), 32'd0);
    captureFrame(0, cap);
    checkOutput("t2_frame", 32'(cap), 32'(11'b1_010101011_0));
    tick(7);
    checkOutput("t2_done_early", 32'(txDone), 32'd0);
    tick(1);
    checkOutput("t2_done",        32'(txDone), 32'd1);
    checkOutput("t2_active_fall", 32'(txActive), 32'd0);
    checkOutput("t2_idle_line",   32'(txSerial), 32'd1);
    tick(1);
    checkOutput("t2_done_width", 32'(txDone), 32'd0);
    tick(2);
    checkOutput("t2_done_count", 32'(doneCount - doneMark), 32'd1);

    // Burst of six words; the sixth must wait for the first Done
    doneMark = doneCount;
    applyStimulus(1'b1, burst[0]);
    tick(1);
    applyStimulus(1'b1, burst[1]);
    tick(1);
    checkOutput("t3_fall0", 32'(txSerial), 32'd0);
    applyStimulus(1'b1, burst[2]);
    tick(1);
    applyStimulus(1'b1, burst[3]);
    tick(1);
    applyStimulus(1'b1, burst[4]);
    tick(1);
    checkOutput("t3_full_count", 32'(txIf.o_Fifo_Count), 32'd4);
    checkOutput("t3_full_ready", 32'(txIf.o_Tx_Ready), 32'd0);
    applyStimulus(1'b1, burst[5]);
    captureFrame(3, cap);
    checkOutput("t3_frame0", 32'(cap), 32'(makeFrame(burst[0])));
    tick(7);
    checkOutput("t3_held_count", 32'(txIf.o_Fifo_Count), 32'd4);
    checkOutput("t3_gap0_high",  32'(txSerial), 32'd1);
    tick(1);
    checkOutput("t3_done0",          32'(txDone), 32'd1);
    checkOutput("t3_b2b_fall0",      32'(txSerial), 32'd0);
    checkOutput("t3_active_hold0",   32'(txActive), 32'd1);
    checkOutput("t4_refused_count",  32'(txIf.o_Fifo_Count), 32'd3);
    checkOutput("t4_ready_again",    32'(txIf.o_Tx_Ready), 32'd1);
    tick(1);
    checkOutput("t4_accept_count",   32'(txIf.o_Fifo_Count), 32'd4);
    applyStimulus(1'b0, '0);
    for (int k = 1; k < 6; k++) begin
      captureFrame((k == 1) ? 1 : 0, cap);
      checkOutput($sformatf("t3_frame%0d", k), 32'(cap), 32'(makeFrame(burst[k])));
      tick(7);
      checkOutput($sformatf("t3_gap%0d_high", k), 32'(txSerial), 32'd1);
      tick(1);
      checkOutput($sformatf("t3_done%0d", k), 32'(txDone), 32'd1);
      checkOutput($sformatf("t3_line%0d", k), 32'(txSerial), (k < 5) ? 32'd0 : 32'd1);
      checkOutput($sformatf("t3_active%0d", k), 32'(txActive), (k < 5) ? 32'd1 : 32'd0);
      checkOutput($sformatf("t3_count%0d", k), 32'(txIf.o_Fifo_Count), 32'(countAfter[k-1]));
    end
    tick(2);
    checkOutput("t3_done_count", 32'(doneCount - doneMark), 32'd6);

    // Reset in the middle of data bit 4 with two words still queued
    applyStimulus(1'b1, 9'h1EF);
    tick(1);
    applyStimulus(1'b1, 9'h055);
    tick(1);
    applyStimulus(1'b1, 9'h0F0);
    tick(1);
    applyStimulus(1'b0, '0);
    checkOutput("t5_queued", 32'(txIf.o_Fifo_Count), 32'd2);
    tick(87);
    checkOutput("t5_bit4", 32'(txSerial), 32'd0);
    doneMark = doneCount;
    resetN = 1'b0;
    #1;
    checkOutput("t5_async_line",   32'(txSerial), 32'd1);
    checkOutput("t5_flush_count",  32'(txIf.o_Fifo_Count), 32'd0);
    checkOutput("t5_active_clear", 32'(txActive), 32'd0);
    tick(3);
    resetN = 1'b1;
    sawLow  = 1'b0;
    sawDone = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick(1);
      if (txSerial !== 1'b1) sawLow = 1'b1;
      if (txDone !== 1'b0) sawDone = 1'b1;
    end
    checkOutput("t5_stays_idle", 32'(sawLow), 32'd0);
    checkOutput("t5_no_done",    32'(sawDone), 32'd0);
    checkOutput("t5_done_count", 32'(doneCount - doneMark), 32'd0);

    // Two back-to-back words decoded as a receiver would see them
    doneMark = doneCount;
    applyStimulus(1'b1, 9'h0AB);
    tick(1);
    applyStimulus(1'b1, 9'h13F);
    tick(1);
    applyStimulus(1'b0, '0);
    checkOutput("t6_fall0", 32'(txSerial), 32'd0);
    captureFrame(0, cap);
    checkOutput("t6_rx0_word",  32'(cap[9:1]), 32'h0AB);
    checkOutput("t6_rx0_frame", 32'({cap[10], cap[0]}), 32'd2);
    tick(8);
    checkOutput("t6_fall1", 32'(txSerial), 32'd0);
    captureFrame(0, cap);
    checkOutput("t6_rx1_word",  32'(cap[9:1]), 32'h13F);
    checkOutput("t6_rx1_frame", 32'({cap[10], cap[0]}), 32'd2);
    tick(10);
    checkOutput("t6_done_count", 32'(doneCount - doneMark), 32'd2);
    checkOutput("t6_idle_line",  32'(txSerial), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
